// File: rtl/vga_sync_generator.sv
// VGA timing generator: free-running column/row counters with registered
// sync, visible and start-of-line/frame strobes, gated by an
// IDLE/RUN/DRAIN controller that only stops at a frame boundary.
module vga_sync_generator #(
  parameter int HOR_Visible_Area = 800,
  parameter int HOR_Front_porch  = 56,
  parameter int HOR_Sync_pulse   = 120,
  parameter int HOR_Back_porch   = 64,
  parameter int VER_Visible_Area = 600,
  parameter int VER_Front_porch  = 37,
  parameter int VER_Sync_pulse   = 6,
  parameter int VER_Back_porch   = 23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [11:0] display_col,
  output logic [10:0] display_row,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        running,
  output logic [1:0]  debug_state
);

  localparam int HOR_TOTAL = HOR_Visible_Area + HOR_Front_porch + HOR_Sync_pulse + HOR_Back_porch;
  localparam int VER_TOTAL = VER_Visible_Area + VER_Front_porch + VER_Sync_pulse + VER_Back_porch;

  localparam logic [11:0] H_LAST       = 12'(HOR_TOTAL - 1);
  localparam logic [11:0] H_VIS        = 12'(HOR_Visible_Area);
  localparam logic [11:0] H_SYNC_START = 12'(HOR_Visible_Area + HOR_Front_porch);
  localparam logic [11:0] H_SYNC_END   = 12'(HOR_Visible_Area + HOR_Front_porch + HOR_Sync_pulse);
  localparam logic [10:0] V_LAST       = 11'(VER_TOTAL - 1);
  localparam logic [10:0] V_VIS        = 11'(VER_Visible_Area);
  localparam logic [10:0] V_SYNC_START = 11'(VER_Visible_Area + VER_Front_porch);
  localparam logic [10:0] V_SYNC_END   = 11'(VER_Visible_Area + VER_Front_porch + VER_Sync_pulse);

  // IDLE = 0, RUN = 1, DRAIN = 2 (visible on debug_state)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic        visible_q, hsync_q, vsync_q, line_start_q, frame_start_q, running_q;
  logic        visible_d, hsync_d, vsync_d, line_start_d, frame_start_d, running_d;

  logic col_last, row_last, frame_last, active_d;

  assign col_last   = (col_q == H_LAST);
  assign row_last   = (row_q == V_LAST);
  assign frame_last = col_last && row_last;

  // Next state and next counter values. A stop request (enable low) only
  // takes effect at the frame boundary; on that boundary the controller
  // goes straight to IDLE so it never starts a frame it will not finish.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        col_d = '0;
        row_d = '0;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        col_d = col_last ? 12'd0 : col_q + 12'd1;
        row_d = col_last ? (row_last ? 11'd0 : row_q + 11'd1) : row_q;
        if (enable) begin
          state_d = ST_RUN;
        end else if (frame_last) begin
          state_d = ST_IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // Decode strobes from the next counter values so the registered strobes
  // line up with the counters they describe.
  always_comb begin
    active_d      = (state_d != ST_IDLE);
    visible_d     = active_d && (col_d < H_VIS) && (row_d < V_VIS);
    hsync_d       = active_d && (col_d >= H_SYNC_START) && (col_d < H_SYNC_END);
    vsync_d       = active_d && (row_d >= V_SYNC_START) && (row_d < V_SYNC_END);
    line_start_d  = active_d && (col_d == 12'd0);
    frame_start_d = active_d && (col_d == 12'd0) && (row_d == 11'd0);
    running_d     = active_d;
  end

  // State, counters and output registers; reset clears everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      visible_q     <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      visible_q     <= visible_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign display_col = col_q;
  assign display_row = row_q;
  assign visible     = visible_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator using a shrunk timing (15 x 13 frame) so
// several whole frames fit in a short run.
module tb_vga_sync_generator;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 15
  localparam int VT = VV + VF + VS + VB;   // 13
  localparam int FRAME = HT * VT;          // 195

  typedef struct packed {
    logic [11:0] col;
    logic [10:0] row;
    logic        vis, hs, vs, ls, fs, run;
  } exp_t;

  typedef struct {
    int   k;
    exp_t e;
  } vec_t;

  // Clock / reset
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        visible, hsync, vsync, line_start, frame_start, running;
  logic [1:0]  debug_state;

  always #10 clock = ~clock;

  vga_sync_generator #(
    .HOR_Visible_Area(HV), .HOR_Front_porch(HF), .HOR_Sync_pulse(HS), .HOR_Back_porch(HB),
    .VER_Visible_Area(VV), .VER_Front_porch(VF), .VER_Sync_pulse(VS), .VER_Back_porch(VB)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .display_col(display_col), .display_row(display_row),
    .visible(visible), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .running(running), .debug_state(debug_state)
  );

  int checks = 0;
  int errors = 0;

  function automatic exp_t actual();
    return '{display_col, display_row, visible, hsync, vsync, line_start, frame_start, running};
  endfunction

  function automatic exp_t zero_out();
    return '0;
  endfunction

  // Expected outputs k cycles into a run that started at col=0,row=0.
  function automatic exp_t model(int k);
    exp_t e;
    int c, r;
    c = k % HT;
    r = (k / HT) % VT;
    e.col = 12'(c);
    e.row = 11'(r);
    e.vis = (c < HV) && (r < VV);
    e.hs  = (c >= HV + HF) && (c < HV + HF + HS);
    e.vs  = (r >= VV + VF) && (r < VV + VF + VS);
    e.ls  = (c == 0);
    e.fs  = (c == 0) && (r == 0);
    e.run = 1'b1;
    return e;
  endfunction

  function automatic vec_t mk(int k, int c, int r, logic vi, logic h, logic v,
                              logic l, logic f, logic rn);
    vec_t t;
    t.k = k;
    t.e = '{12'(c), 11'(r), vi, h, v, l, f, rn};
    return t;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got col=%0d row=%0d vis=%b hs=%b vs=%b ls=%b fs=%b run=%b, want col=%0d row=%0d vis=%b hs=%b vs=%b ls=%b fs=%b run=%b",
               name, $time, act.col, act.row, act.vis, act.hs, act.vs, act.ls, act.fs, act.run,
               exp.col, exp.row, exp.vis, exp.hs, exp.vs, exp.ls, exp.fs, exp.run);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // Driver: reset, hold IDLE for one cycle, then enable. Returns at the
  // negedge where the first RUN cycle (k=0) is presented.
  task automatic restart();
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("reset_zero", zero_out());
    reset = 1'b1;
    @(negedge clock);
    check("idle_zero", zero_out());
    enable = 1'b1;
    @(negedge clock);
  endtask

  vec_t vecs[20];

  initial begin
    int vi, last_fs, last_ls;

    vecs[0]  = mk(0,   0,  0, 1, 0, 0, 1, 1, 1);
    vecs[1]  = mk(1,   1,  0, 1, 0, 0, 0, 0, 1);
    vecs[2]  = mk(7,   7,  0, 1, 0, 0, 0, 0, 1);
    vecs[3]  = mk(8,   8,  0, 0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(9,   9,  0, 0, 0, 0, 0, 0, 1);
    vecs[5]  = mk(10,  10, 0, 0, 1, 0, 0, 0, 1);
    vecs[6]  = mk(12,  12, 0, 0, 1, 0, 0, 0, 1);
    vecs[7]  = mk(13,  13, 0, 0, 0, 0, 0, 0, 1);
    vecs[8]  = mk(14,  14, 0, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(15,  0,  1, 1, 0, 0, 1, 0, 1);
    vecs[10] = mk(89,  14, 5, 0, 0, 0, 0, 0, 1);
    vecs[11] = mk(90,  0,  6, 0, 0, 0, 1, 0, 1);
    vecs[12] = mk(119, 14, 7, 0, 0, 0, 0, 0, 1);
    vecs[13] = mk(120, 0,  8, 0, 0, 1, 1, 0, 1);
    vecs[14] = mk(130, 10, 8, 0, 1, 1, 0, 0, 1);
    vecs[15] = mk(149, 14, 9, 0, 0, 1, 0, 0, 1);
    vecs[16] = mk(150, 0, 10, 0, 0, 0, 1, 0, 1);
    vecs[17] = mk(194, 14, 12, 0, 0, 0, 0, 0, 1);
    vecs[18] = mk(195, 0,  0, 1, 0, 0, 1, 1, 1);
    vecs[19] = mk(585, 0,  0, 1, 0, 0, 1, 1, 1);

    // Three continuous frames: table vectors, per-cycle model, strobe spacing.
    restart();
    vi = 0;
    last_fs = -1;
    last_ls = -1;
    for (int k = 0; k <= 3 * FRAME; k++) begin
      if (k > 0) @(negedge clock);
      check($sformatf("run_k%0d", k), model(k));
      if (vi < 20 && vecs[vi].k == k) begin
        check($sformatf("vec%0d_k%0d", vi, k), vecs[vi].e);
        vi++;
      end
      if (frame_start) begin
        if (last_fs >= 0) check_int("frame_period", k - last_fs, FRAME);
        last_fs = k;
      end
      if (line_start) begin
        if (last_ls >= 0) check_int("line_period", k - last_ls, HT);
        last_ls = k;
      end
    end
    check_int("table_consumed", vi, 20);

    // Drop enable mid-frame (row 3): frame completes, then everything idles.
    restart();
    for (int k = 1; k <= FRAME + 3; k++) begin
      if (k == 50) enable = 1'b0;
      @(negedge clock);
      if (k < FRAME) check($sformatf("drain_k%0d", k), model(k));
      else check($sformatf("drain_idle_k%0d", k), zero_out());
    end
    check_int("drain_idle_state", int'(debug_state), 0);

    // Drop at row 3, re-enable at row 5: counting stays continuous.
    restart();
    for (int k = 1; k <= FRAME + 2; k++) begin
      if (k == 51) enable = 1'b0;
      if (k == 81) enable = 1'b1;
      @(negedge clock);
      check($sformatf("resume_k%0d", k), model(k));
      if (k == 60) check_int("resume_drain_state", int'(debug_state), 2);
      if (k == 90) check_int("resume_run_state", int'(debug_state), 1);
    end

    // Asynchronous reset in the middle of hsync.
    restart();
    for (int k = 1; k <= 11; k++) @(negedge clock);
    check("pre_reset_hsync", model(11));
    #5 reset = 1'b0;
    #1 check("async_reset_zero", zero_out());
    @(negedge clock);
    check("reset_held_zero", zero_out());
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clock);
    check("post_reset_start", model(0));
    @(negedge clock);
    check("post_reset_k1", model(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  HOR_Visible_Area  800   active pixels per line
  HOR_Front_porch   56    clocks after active video, before hsync
  HOR_Sync_pulse    120   hsync width in clocks
  HOR_Back_porch    64    clocks after hsync, before next line
  VER_Visible_Area  600   active lines per frame
  VER_Front_porch   37    lines after active video, before vsync
  VER_Sync_pulse    6     vsync width in lines
  VER_Back_porch    23    lines after vsync, before next frame
REQ-002 HOR_TOTAL (1040) and VER_TOTAL (666) SHALL be derived as the sum of the four horizontal and the four vertical parameters respectively, not set independently.
REQ-003 Ports, one per line: name, direction, width, meaning.
  clock        in   1   pixel clock, 50 MHz, 800x600 @ 72 Hz
  reset        in   1   asynchronous, active-low reset
  enable       in   1   request video output; level-sensitive
  display_col  out  12  horizontal count, 0..HOR_TOTAL-1
  display_row  out  11  vertical count, 0..VER_TOTAL-1
  visible      out  1   high when col < 800 and row < 600
  hsync        out  1   horizontal sync, active-high
  vsync        out  1   vertical sync, active-high
  line_start   out  1   one-clock pulse at col==0
  frame_start  out  1   one-clock pulse at col==0 and row==0
  running      out  1   high in states RUN and DRAIN
REQ-004 Reset SHALL be asynchronous and active-low; clock SHALL be the only clock.

Function
REQ-005 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-006 IDLE->RUN SHALL occur on the first clock edge on which enable is sampled high; the first RUN cycle SHALL present col=0, row=0, with frame_start=1 and line_start=1.
REQ-007 RUN->DRAIN SHALL occur on the edge on which enable is sampled low; counting continues unchanged.
REQ-008 DRAIN->IDLE SHALL occur on the edge after the last clock of the frame (col=HOR_TOTAL-1, row=VER_TOTAL-1); frames SHALL never be truncated.
REQ-009 DRAIN->RUN SHALL occur if enable is sampled high again before the frame ends, with no counter discontinuity.
REQ-010 In IDLE, counters SHALL hold at 0, and all outputs except display_col/display_row SHALL be 0.
REQ-011 display_col SHALL increment by 1 per clock while running, wrapping from HOR_TOTAL-1 to 0.
REQ-012 display_row SHALL increment only on the col wrap, wrapping from VER_TOTAL-1 to 0 on the same edge that col wraps.
REQ-013 hsync SHALL be 1 exactly for col in [856, 975] (120 clocks).
REQ-014 vsync SHALL be 1 exactly for row in [637, 642] (6 full lines), changing on the col=0 edge.
REQ-015 visible, hsync, vsync, line_start and frame_start SHALL be registered outputs, cycle-aligned with the display_col/display_row values they describe (zero relative latency), and glitch-free.
REQ-016 Counters SHALL never exceed their TOTAL-1 values; no out-of-range state SHALL be reachable.

Reset
REQ-017 While reset=0, the block SHALL be forced to IDLE immediately, independent of clock.
REQ-018 While reset=0, display_col, display_row, visible, hsync, vsync, line_start, frame_start and running SHALL all be 0.
REQ-019 After reset deasserts, the first transition SHALL follow REQ-006.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no further sync pulses.

Verification
REQ-021 Reset, then enable=1 held for 3 frames -> running=1 on the first edge; frame_start pulses every 692,640 clocks; line_start pulses every 1040 clocks.
REQ-022 Per line, check hsync: high for 120 clocks starting at col=856; visible high for 800 clocks at col 0..799; both never high together.
REQ-023 Per frame, check vsync: high for 6240 clocks starting at row=637, col=0; visible high on rows 0..599 only; no visible during vsync.
REQ-024 Drop enable at row=300 -> counting continues to col=1039, row=665; running=0 and all outputs 0 on the next edge; no partial frame.
REQ-025 Drop enable at row=300, then reassert it at row=500 -> state returns to RUN; counters remain continuous; the next frame_start falls exactly 692,640 clocks after the previous one.
REQ-026 Assert reset=0 asynchronously mid-hsync (col=900) -> hsync and all other outputs go to 0 before the next clock edge; after release with enable=1, col=0, row=0 and frame_start=1.
